// File: rtl/clb_config_loader.sv
// Bitstream configuration loader for a daisy-chained row of CLBs.
// Accepts bytes from the host over valid/ready, shifts them LSB first into
// the chain for exactly NUM_CLB*BITS_PER_CLB enabled cycles, then reports done.
// Optional readback verification is built when CLB_CFG_READBACK_EN is defined:
// the chain is rotated once through a loopback and the CRC-16-CCITT of the
// read-out bits is compared against the CRC of the bits loaded.
module clb_config_loader #(
  parameter int NUM_CLB      = 4,
  parameter int BITS_PER_CLB = 17
) (
  input  logic       prog_clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] cfg_data,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic       chain_prog_in,
  output logic       chain_prog_en,
  input  logic       chain_prog_out,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int CHAIN_LEN = NUM_CLB * BITS_PER_CLB;
  localparam int NUM_BYTES = (CHAIN_LEN + 7) / 8;
  localparam int LAST_BITS = ((CHAIN_LEN % 8) == 0) ? 8 : (CHAIN_LEN % 8);
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int BYTE_W    = $clog2(NUM_BYTES + 1);

  localparam logic [2:0]        LAST_REM  = 3'(LAST_BITS - 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
  localparam logic [BYTE_W-1:0] ALL_BYTES = BYTE_W'(NUM_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t            state, state_n;
  logic [6:0]        shreg, shreg_n;     // undriven bits of the current byte
  logic [2:0]        rem, rem_n;         // how many of those bits remain
  logic [BYTE_W-1:0] byte_cnt, byte_n;
  logic [CNT_W-1:0]  bit_cnt, bit_n;     // enabled shifts in LOAD or VERIFY
  logic              prog_in_q, prog_in_n;
  logic              prog_en_q, prog_en_n;
  logic              ready_q, ready_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              accept;
  logic              load_entry;

`ifdef CLB_CFG_READBACK_EN
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  logic [15:0] crc_load, crc_rb, crc_rb_n;
  logic        crc_match;
  logic        error_q;

  // The decision uses the readback CRC including the bit sampled this edge.
  assign crc_rb_n  = crc16_step(crc_rb, chain_prog_out);
  assign crc_match = (crc_rb_n == crc_load);
`endif

  assign accept     = ready_q && cfg_valid;
  assign load_entry = (state != ST_LOAD) && (state != ST_VERIFY) && start;

  // Next-state, serialiser and registered-output decode.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    rem_n     = rem;
    byte_n    = byte_cnt;
    bit_n     = bit_cnt;
    prog_in_n = 1'b0;
    prog_en_n = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_n = ST_LOAD;
          rem_n   = '0;
          byte_n  = '0;
          bit_n   = '0;
        end
      end
      ST_LOAD: begin
        if (prog_en_q) bit_n = bit_cnt + 1'b1;
        if (prog_en_q && (bit_cnt == LAST_BIT)) begin
          // The last chain bit is being driven; the chain samples it now.
          bit_n = '0;
`ifdef CLB_CFG_READBACK_EN
          state_n   = ST_VERIFY;
          prog_en_n = 1'b1;
`else
          state_n = ST_DONE;
`endif
        end else if (accept) begin
          prog_in_n = cfg_data[0];
          prog_en_n = 1'b1;
          shreg_n   = cfg_data[7:1];
          rem_n     = (byte_cnt == LAST_BYTE) ? LAST_REM : 3'd7;
          byte_n    = byte_cnt + 1'b1;
        end else if (rem != 3'd0) begin
          prog_in_n = shreg[0];
          prog_en_n = 1'b1;
          shreg_n   = {1'b0, shreg[6:1]};
          rem_n     = rem - 1'b1;
        end
      end
`ifdef CLB_CFG_READBACK_EN
      ST_VERIFY: begin
        prog_en_n = 1'b1;
        bit_n     = bit_cnt + 1'b1;
        if (bit_cnt == LAST_BIT) begin
          prog_en_n = 1'b0;
          bit_n     = '0;
          state_n   = crc_match ? ST_DONE : ST_ERROR;
        end
      end
`endif
      default: state_n = ST_IDLE;
    endcase
    // Ready whenever no undriven bit will be left after this edge.
    ready_n = (state_n == ST_LOAD) && (rem_n == 3'd0) && (byte_n < ALL_BYTES);
    busy_n  = (state_n == ST_LOAD) || (state_n == ST_VERIFY);
    done_n  = (state_n == ST_DONE);
  end

  // Control state and registered outputs.
  always_ff @(posedge prog_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rem       <= '0;
      byte_cnt  <= '0;
      bit_cnt   <= '0;
      prog_in_q <= 1'b0;
      prog_en_q <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      rem       <= rem_n;
      byte_cnt  <= byte_n;
      bit_cnt   <= bit_n;
      prog_in_q <= prog_in_n;
      prog_en_q <= prog_en_n;
      ready_q   <= ready_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
    end
  end

  // Byte buffer datapath; its contents only matter while rem is non-zero.
  always_ff @(posedge prog_clk) begin
    shreg <= shreg_n;
  end

  assign cfg_ready     = ready_q;
  assign chain_prog_en = prog_en_q;
  assign busy          = busy_q;
  assign done          = done_q;

`ifdef CLB_CFG_READBACK_EN
  // CRC of the bits shifted in during LOAD and read out during VERIFY.
  always_ff @(posedge prog_clk) begin
    if (load_entry) begin
      crc_load <= 16'hFFFF;
      crc_rb   <= 16'hFFFF;
    end else if (prog_en_q) begin
      if (state == ST_LOAD) crc_load <= crc16_step(crc_load, prog_in_q);
      else if (state == ST_VERIFY) crc_rb <= crc_rb_n;
    end
  end

  // Readback mismatch flag, held until the next start.
  always_ff @(posedge prog_clk or negedge rst_n) begin
    if (!rst_n) error_q <= 1'b0;
    else        error_q <= (state_n == ST_ERROR);
  end

  // VERIFY loops the chain output straight back to its input.
  assign chain_prog_in = (state == ST_VERIFY) ? chain_prog_out : prog_in_q;
  assign error         = error_q;
`else
  logic unused_prog_out;
  assign unused_prog_out = chain_prog_out;
  assign chain_prog_in   = prog_in_q;
  assign error           = 1'b0;
`endif

endmodule

// File: tb/tb_clb_config_loader.sv
// Scoreboard bench for clb_config_loader with a behavioural 68-bit CLB chain.
// Each load pushes its expected outcome; the monitor pops on done/error rise.
module tb_clb_config_loader;

  localparam int CHAIN_LEN = 68;
`ifdef CLB_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef logic [7:0] byte_arr_t [9];
  typedef struct {
    logic            exp_done;
    logic            exp_err;
    logic [67:0]     chain;
    bit              chk_chain;
    int              en;
    int              lat;
  } exp_t;

  logic        prog_clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        chain_prog_in;
  logic        chain_prog_en;
  logic        chain_prog_out;
  logic        busy;
  logic        done;
  logic        error;

  logic [67:0] sr;
  logic        flip = 1'b0;
  bit          inj = 1'b0;
  int          cyc = 0;
  int          en_cnt = 0;
  int          en_base = 0;
  int          start_cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];

  clb_config_loader #(.NUM_CLB(4), .BITS_PER_CLB(17)) dut (
    .prog_clk      (prog_clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .chain_prog_in (chain_prog_in),
    .chain_prog_en (chain_prog_en),
    .chain_prog_out(chain_prog_out),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) cyc <= cyc + 1;

  // Behavioural chain: index 0 next to prog_in, index 67 drives prog_out.
  always @(posedge prog_clk) if (chain_prog_en === 1'b1) sr <= {sr[66:0], chain_prog_in};
  assign chain_prog_out = sr[67] ^ flip;

  function automatic void chk(string nm, logic [67:0] act, logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  function automatic logic [67:0] build_chain(byte_arr_t b);
    logic [67:0] c;
    for (int k = 0; k < CHAIN_LEN; k++) c[67-k] = b[k/8][k%8];
    return c;
  endfunction

  // Monitor: counts enabled cycles, injects faults, checks each finished load.
  initial begin
    logic fin, fin_prev;
    exp_t e;
    fin_prev = 1'b0;
    forever begin
      @(negedge prog_clk);
      if (chain_prog_en === 1'b1) en_cnt++;
      flip = inj && ((en_cnt - en_base) == 90);
      fin = (done === 1'b1) || (error === 1'b1);
      if (fin && !fin_prev) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_finish done=%0b error=%0b", done, error);
        end else begin
          e = q.pop_front();
          chk("done", done, e.exp_done);
          chk("error", error, e.exp_err);
          chk("busy_at_finish", busy, 1'b0);
          chk("enable_count", en_cnt - en_base, e.en);
          chk("latency", cyc - start_cyc, e.lat);
          if (e.chk_chain) chk("chain_contents", sr, e.chain);
        end
      end
      fin_prev = fin;
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge prog_clk);
    while (cfg_ready !== 1'b1 && n < 300) begin
      n++;
      @(negedge prog_clk);
    end
    if (cfg_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_wait actual=%0b required=1", cfg_ready);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap, input bit pulse_start);
    cfg_valid = 1'b0;
    if (gap > 0) begin
      wait_ready();
      for (int g = 0; g < gap; g++) begin
        @(posedge prog_clk); #1;
        chk("gap_stall_en", chain_prog_en, 1'b0);
      end
    end
    cfg_data  = d;
    cfg_valid = 1'b1;
    start     = pulse_start;
    wait_ready();
    @(posedge prog_clk); #1;
    cfg_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge prog_clk); #1;
    start     = 1'b0;
    start_cyc = cyc;
    en_base   = en_cnt;
  endtask

  task automatic run_load(input byte_arr_t b, input int gap_at, input int restart_at,
                          input bit inject, input bit exp_err);
    exp_t e;
    int n;
    e.exp_done  = !exp_err;
    e.exp_err   = exp_err;
    e.chain     = build_chain(b);
    e.chk_chain = !inject;
    e.en        = RB ? 2 * CHAIN_LEN : CHAIN_LEN;
    e.lat       = 69 + ((gap_at >= 0) ? 5 : 0) + (RB ? CHAIN_LEN : 0);
    q.push_back(e);
    inj = inject;
    do_start();
    chk("busy_after_start", busy, 1'b1);
    chk("ready_after_start", cfg_ready, 1'b1);
    for (int i = 0; i < 9; i++) send_byte(b[i], (i == gap_at) ? 5 : 0, (i == restart_at));
    chk("ready_after_last_byte", cfg_ready, 1'b0);
    n = 0;
    while (q.size() != 0 && n < 600) begin
      @(posedge prog_clk);
      n++;
    end
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL finish_timeout pending=%0d required=0", q.size());
      q.delete();
    end
    inj = 1'b0;
  endtask

  // Stimulus.
  initial begin
    byte_arr_t pat_a, pat_b;
    int n;
    pat_a = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h96, 8'h69, 8'h81, 8'h7E, 8'hB2};
    pat_b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'hF5};
    rst_n = 1'b0;
    start = 1'b0;
    cfg_valid = 1'b0;
    cfg_data = 8'h00;
    repeat (2) @(posedge prog_clk);
    #1;
    chk("rst_cfg_ready", cfg_ready, 1'b0);
    chk("rst_prog_in", chain_prog_in, 1'b0);
    chk("rst_prog_en", chain_prog_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    rst_n = 1'b1;
    @(posedge prog_clk); #1;

    // Back-to-back stream.
    run_load(pat_a, -1, -1, 1'b0, 1'b0);

    // Bytes offered while not loading are ignored.
    cfg_data = 8'hFF;
    cfg_valid = 1'b1;
    repeat (3) @(posedge prog_clk);
    #1;
    chk("idle_ready", cfg_ready, 1'b0);
    chk("idle_prog_en", chain_prog_en, 1'b0);
    chk("done_holds", done, 1'b1);
    cfg_valid = 1'b0;

    // Five-cycle host gap at a byte boundary.
    run_load(pat_a, 4, -1, 1'b0, 1'b0);

    // start pulsed mid-load is ignored.
    run_load(pat_b, -1, 3, 1'b0, 1'b0);

    // Asynchronous reset after 30 shifts.
    do_start();
    for (int i = 0; i < 4; i++) send_byte(pat_b[i], 0, 1'b0);
    n = 0;
    while ((en_cnt - en_base) < 30 && n < 100) begin
      @(negedge prog_clk);
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cfg_ready", cfg_ready, 1'b0);
    chk("async_rst_prog_in", chain_prog_in, 1'b0);
    chk("async_rst_prog_en", chain_prog_en, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_done", done, 1'b0);
    chk("async_rst_error", error, 1'b0);
    @(posedge prog_clk); #1;
    rst_n = 1'b1;
    @(posedge prog_clk); #1;
    run_load(pat_a, -1, -1, 1'b0, 1'b0);

`ifdef CLB_CFG_READBACK_EN
    // Corrupt one readback bit, then recover with a clean load.
    run_load(pat_b, -1, -1, 1'b1, 1'b1);
    chk("error_holds", error, 1'b1);
    run_load(pat_b, -1, -1, 1'b0, 1'b0);
`endif

    repeat (3) @(posedge prog_clk);
    #1;
    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #400000;
    $display("FAIL global_timeout cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/clb_config_loader.md
# clb_config_loader

Bitstream configuration controller for a daisy-chained row of CLBs. It accepts configuration bytes from a host over a valid/ready handshake, serialises them, and drives the shared serial programming chain (prog_in/prog_en) for exactly NUM_CLB*BITS_PER_CLB shift cycles. It sits between the host configuration port and the first CLB's prog_in, and optionally verifies the loaded chain by loopback readback. While it is programming, CLB outputs are forced low because prog_en is high.

## Interface
- NUM_CLB, 4, number of CLBs in the chain.
- BITS_PER_CLB, 17, configuration bits per CLB: 16 LUT bits plus 1 output-mux select.
- (derived) CHAIN_LEN = NUM_CLB*BITS_PER_CLB; NUM_BYTES = ceil(CHAIN_LEN/8).
- prog_clk  in  1  single clock, shared with the CLB chain's prog_clk.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- cfg_data  in  8  configuration byte, sent LSB first.
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  the loader accepts a byte this cycle.
- chain_prog_in  out  1  serial bit into the first CLB.
- chain_prog_en  out  1  shift enable for the whole chain.
- chain_prog_out  in  1  serial bit out of the last CLB.
- busy  out  1  high in LOAD and VERIFY.
- done  out  1  load complete and, if enabled, verified.
- error  out  1  readback mismatch; tied 0 when the readback macro is absent.

## Operation
- States: IDLE, LOAD, VERIFY, DONE, ERROR. Reset enters IDLE.
- IDLE/DONE/ERROR to LOAD on start. On entry to LOAD, the bit counter, byte buffer and CRC are cleared, and done and error are cleared.
- LOAD:
  - A byte is accepted when cfg_valid && cfg_ready. It is then shifted out over 8 cycles, LSB first.
  - Each shifted bit drives chain_prog_in with chain_prog_en=1 for that cycle.
  - If no byte is buffered, chain_prog_en=0 (stall). The chain holds its contents during a stall.
  - The final byte contributes only its low CHAIN_LEN mod 8 bits (all 8 bits if the remainder is 0). Its upper bits are discarded and never shifted.
  - Exactly CHAIN_LEN enabled cycles occur per load. The first bit shifted ends up at the far end of the chain, in bit 0 of the last CLB.
  - After the last bit, the state moves to VERIFY if the macro is defined, otherwise to DONE.
- VERIFY (macro only):
  - Runs CHAIN_LEN consecutive cycles with chain_prog_en=1 and chain_prog_in = chain_prog_out. This is a combinational loopback, so the chain rotates back to its loaded contents.
  - The CRC of the bits read out of chain_prog_out is compared with the CRC of the bits shifted in during LOAD.
  - Match leads to DONE; mismatch leads to ERROR.
- CRC: CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, bit-serial, updated on each enabled shift cycle.
- DONE: done=1, error=0. Holds until start.
- ERROR: error=1, done=0. Holds until start.
- start while busy is ignored. cfg_valid outside LOAD is ignored and cfg_ready stays 0.

## Timing
- Reset values: cfg_ready=0, chain_prog_in=0, chain_prog_en=0, busy=0, done=0, error=0.
- Reset mid-load takes effect immediately and asynchronously: all outputs go to their reset values and the chain contents are undefined.
- All outputs are registered, except chain_prog_in during VERIFY.
- start is sampled at edge N; state=LOAD and busy=1 after N, and cfg_ready=1 after N.
- A byte accepted at edge A drives bit 0 with chain_prog_en=1 after A; the chain samples it at A+1.
- cfg_ready is high when the buffer is empty or on the cycle its last bit is driven. Back-to-back bytes therefore give continuous enable with no bubble.
- cfg_ready drops after the last byte is accepted.
- Without the macro, done=1 on the cycle after the final enabled shift cycle, and busy drops at the same time. Minimum load is CHAIN_LEN+2 cycles from start.
- With the macro, VERIFY adds CHAIN_LEN cycles and the done/error decision registers one cycle after the last VERIFY shift.

## Configuration
- CLB_CFG_READBACK_EN:
  - Defined: the VERIFY state, both CRC generators, and the error output are present.
  - Undefined: LOAD goes directly to DONE, no CRC logic is generated, and error is constant 0.

## Test plan
- NUM_CLB=4 (CHAIN_LEN=68, 9 bytes), back-to-back valid → exactly 68 chain_prog_en cycles; the chain model matches the bitstream; the upper 4 bits of byte 8 are never shifted; done=1 at cycle 70.
- Same stream with cfg_valid deasserted for 5 cycles mid-byte-boundary → chain_prog_en=0 during the gap, still 68 total enables, identical chain contents.
- Readback enabled with a correct chain model → 68 VERIFY enables, chain contents unchanged afterwards, done=1, error=0.
- Readback enabled with one chain_prog_out bit inverted in VERIFY → error=1, done=0; a subsequent start with a clean model → done=1.
- rst_n low after 30 shifts → all outputs 0 immediately; a new start with 9 bytes completes normally with 68 enables.
- start pulsed during LOAD → ignored; the bit count and final contents are unaffected.
